motor_cmd_queue: RTL and testbench

//  Command front-end directly upstream of the stepper Control stage. Accepts (motor, target value)

---
 rtl/motor_ctrl_pkg.sv | 25 ++
 rtl/cmd_fifo.sv | 83 ++++++++
 rtl/motor_cmd_queue.sv | 162 ++++++++++++++++
 tb/tb_motor_cmd_queue.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the stepper command path.
// Holds the default motor-id / position widths, the motor count, and the
// command-sequencer state encoding (also used by the Control/PulseSign benches).
// Also provides a small helper that sizes cycle counters.
package motor_ctrl_pkg;

    localparam int NUM_MOTORS_DEFAULT = 6;
    localparam int MOTOR_W_DEFAULT    = 3;
    localparam int VALUE_W_DEFAULT    = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_SETUP     = 3'd2,
        ST_LOCK      = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_WAIT_DONE = 3'd5
    } motor_state_t;

    // Bits needed for a counter that runs 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for queued motor commands.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the queue)
//   push       : write push_data (ignored when full)
//   push_data  : command word {motor, value}
//   pop        : discard the head entry (ignored when empty)
//   head_data  : current head entry, valid whenever empty is low
//   count      : entries stored, 0..DEPTH
//   empty      : no entries stored
//   ready      : registered "not full", low while rst is high
module cmd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH by themselves.
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             ready_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_reg != FULL_COUNT);
    assign do_pop  = pop && (count_reg != '0);

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            // Registered from the next count so it always equals !full of count_reg.
            ready_reg <= (count_next != FULL_COUNT);
        end
    end

    // The head is read asynchronously: the sequencer loads it in the same
    // cycle it pops, which keeps the push-to-InputLock latency at 3 edges.
    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign ready     = ready_reg;

endmodule

// File: rtl/motor_cmd_queue.sv
// Command front-end for the stepper Control stage.
// Buffers (motor, value) commands and issues them one at a time on Control's
// Motor/Value/InputLock protocol, waiting for Busy low before each issue.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake, transfer when both high
//   cmd_motor/cmd_value  : offered command
//   InitFlag             : per-motor homed flags
//   Busy                 : PulseSign is emitting pulses
//   Motor/Value          : command presented to Control (held between issues)
//   InputLock            : Control latch strobe, LOCK_CYCLES long
//   q_count              : entries queued
//   err_drop             : one-cycle pulse when the head command is discarded
//   idle                 : sequencer idle, queue empty, Busy low
module motor_cmd_queue
    import motor_ctrl_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int NUM_MOTORS   = NUM_MOTORS_DEFAULT,
    parameter int MOTOR_W      = MOTOR_W_DEFAULT,
    parameter int VALUE_W      = VALUE_W_DEFAULT,
    parameter int LOCK_CYCLES  = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [MOTOR_W-1:0]      cmd_motor,
    input  logic [VALUE_W-1:0]      cmd_value,
    input  logic [NUM_MOTORS-1:0]   InitFlag,
    input  logic                    Busy,
    output logic [MOTOR_W-1:0]      Motor,
    output logic [VALUE_W-1:0]      Value,
    output logic                    InputLock,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    err_drop,
    output logic                    idle
);

    localparam int CMD_W    = MOTOR_W + VALUE_W;
    localparam int ID_SPACE = 2 ** MOTOR_W;
    localparam int LOCK_W   = cnt_width(LOCK_CYCLES);
    localparam int TIMER_W  = cnt_width(BUSY_TIMEOUT);
    localparam logic [LOCK_W-1:0]  LOCK_LAST    = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

    motor_state_t        state_reg, state_next;
    logic [MOTOR_W-1:0]  motor_reg;
    logic [VALUE_W-1:0]  value_reg;
    logic [LOCK_W-1:0]   lock_cnt_reg, lock_cnt_next;
    logic [TIMER_W-1:0]  timer_reg, timer_next;
    logic                pop;
    logic                fifo_empty;
    logic [CMD_W-1:0]    head_data;
    logic [ID_SPACE-1:0] motor_ok_vec;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_motor, cmd_value}),
        .pop       (pop),
        .head_data (head_data),
        .count     (q_count),
        .empty     (fifo_empty),
        .ready     (cmd_ready)
    );

    // One "may issue" bit per encodable motor id: ids beyond NUM_MOTORS are
    // tied low, so the range check and the homed check become a single lookup.
    generate
        for (genvar gi = 0; gi < ID_SPACE; gi++) begin : g_motor_ok
            if (gi < NUM_MOTORS) begin : g_real
                assign motor_ok_vec[gi] = InitFlag[gi];
            end else begin : g_none
                assign motor_ok_vec[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            motor_reg    <= '0;
            value_reg    <= '0;
            lock_cnt_reg <= '0;
            timer_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
            timer_reg    <= timer_next;
            if (pop) begin
                motor_reg <= head_data[VALUE_W +: MOTOR_W];
                value_reg <= head_data[VALUE_W-1:0];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = '0;
        timer_next    = '0;
        pop           = 1'b0;
        err_drop      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Busy here is motion we did not start; just wait it out.
                if (!fifo_empty && !Busy) begin
                    pop        = 1'b1;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!motor_ok_vec[motor_reg]) begin
                    err_drop   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_LOCK;
            end
            ST_LOCK: begin
                if (lock_cnt_reg == LOCK_LAST) begin
                    state_next = ST_RELEASE;
                end else begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end
            end
            ST_RELEASE: begin
                // A command to the current position produces no motion, so
                // Busy may never rise; give up after BUSY_TIMEOUT cycles.
                if (Busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!Busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign Motor     = motor_reg;
    assign Value     = value_reg;
    assign InputLock = (state_reg == ST_LOCK);
    assign idle      = (state_reg == ST_IDLE) && fifo_empty && !Busy;

endmodule

// File: tb/tb_motor_cmd_queue.sv
module tb_motor_cmd_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_motor;
    logic [9:0] cmd_value;
    logic [5:0] InitFlag;
    logic       Busy;
    logic [2:0] Motor;
    logic [9:0] Value;
    logic       InputLock;
    logic [3:0] q_count;
    logic       err_drop;
    logic       idle;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0] flag;
        int         motor;
        int         value;
        int         busy_len;   // 0: Busy never rises after the lock
        bit         issue;      // 1: expect InputLock pulse, 0: expect err_drop
    } vec_t;

    typedef struct packed {
        logic [2:0] m;
        logic [9:0] v;
    } cmd_t;

    vec_t vecs[8];

    motor_cmd_queue dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_motor (cmd_motor),
        .cmd_value (cmd_value),
        .InitFlag  (InitFlag),
        .Busy      (Busy),
        .Motor     (Motor),
        .Value     (Value),
        .InputLock (InputLock),
        .q_count   (q_count),
        .err_drop  (err_drop),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic bit model_ok(input logic [2:0] m);
        if (m >= 3'd6) return 1'b0;
        return InitFlag[m];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_cmd(input logic [2:0] m, input logic [9:0] v, input string name);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_motor = m;
        cmd_value = v;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check({name, "_accepted"}, ok, 1);
        $display("push %s motor=%0d value=%0d accepted=%0d q_count=%0d", name, m, v, ok, q_count);
    endtask

    task automatic wait_lock(input logic [2:0] m, input logic [9:0] v, input string name,
                             output int lat);
        int  len = 0;
        bit  stable = 1'b1;
        lat = 0;
        while (!InputLock && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lock_seen"}, InputLock, 1);
        if (!InputLock) return;
        check({name, "_motor"}, Motor, m);
        check({name, "_value"}, Value, v);
        while (InputLock && len < 20) begin
            if (Motor !== m || Value !== v) stable = 1'b0;
            @(negedge clk);
            len++;
        end
        check({name, "_lock_len"}, len, 4);
        check({name, "_held"}, stable, 1);
        $display("issue %s motor=%0d value=%0d wait=%0d lock_len=%0d", name, Motor, Value, lat, len);
    endtask

    task automatic wait_drop(input logic [2:0] m, input string name, output int lat);
        lat = 0;
        while (!err_drop && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_drop_seen"}, err_drop, 1);
        check({name, "_drop_motor"}, Motor, m);
        @(negedge clk);
        check({name, "_drop_1cyc"}, err_drop, 0);
        $display("drop %s motor=%0d wait=%0d", name, m, lat);
    endtask

    task automatic motion(input int len, input string name);
        bit quiet = 1'b1;
        Busy = 1'b1;
        repeat (len) begin
            @(negedge clk);
            if (InputLock) quiet = 1'b0;
        end
        Busy = 1'b0;
        check({name, "_no_lock_in_motion"}, quiet, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!idle && n < 32) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, idle, 1);
    endtask

    task automatic expect_timeout(input string name);
        int n = 0;
        while (!idle && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout_cycles"}, n, 16);
        $display("timeout %s cycles=%0d", name, n);
    endtask

    task automatic run_vector(input vec_t vv, input int idx);
        string nm = $sformatf("v%0d", idx);
        int    lat;
        bit    quiet = 1'b1;
        InitFlag = vv.flag;
        push_cmd(vv.motor[2:0], vv.value[9:0], nm);
        if (vv.issue) begin
            wait_lock(vv.motor[2:0], vv.value[9:0], nm, lat);
            check({nm, "_latency"}, lat, 3);
            if (vv.busy_len > 0) begin
                motion(vv.busy_len, nm);
                wait_idle(nm);
            end else begin
                expect_timeout(nm);
            end
        end else begin
            wait_drop(vv.motor[2:0], nm, lat);
            check({nm, "_drop_latency"}, lat, 1);
            check({nm, "_idle_after_drop"}, idle, 1);
            repeat (6) begin
                if (InputLock) quiet = 1'b0;
                @(negedge clk);
            end
            check({nm, "_no_lock"}, quiet, 1);
        end
    endtask

    initial begin
        int lat;
        bit flag_b;
        vecs[0] = '{6'h3F, 2, 7, 20, 1'b1};
        vecs[1] = '{6'h3B, 2, 4, 0, 1'b0};
        vecs[2] = '{6'h3B, 7, 1, 0, 1'b0};
        vecs[3] = '{6'h3F, 1, 3, 0, 1'b1};
        vecs[4] = '{6'h3F, 5, 1023, 3, 1'b1};
        vecs[5] = '{6'h3F, 6, 0, 0, 1'b0};
        vecs[6] = '{6'h3E, 0, 5, 0, 1'b0};
        vecs[7] = '{6'h3E, 3, 512, 1, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_motor = '0; cmd_value = '0;
        InitFlag = 6'h3F; Busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_motor", Motor, 0);
        check("rst_value", Value, 0);
        check("rst_lock", InputLock, 0);
        check("rst_drop", err_drop, 0);
        check("rst_count", q_count, 0);
        check("rst_ready", cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_idle", idle, 1);

        for (int i = 0; i < 8; i++) run_vector(vecs[i], i);

        // Three commands queue up behind external motion, then drain in order.
        InitFlag = 6'h3F;
        Busy = 1'b1;
        push_cmd(3'd2, 10'd7, "t2a");
        push_cmd(3'd2, 10'd5, "t2b");
        push_cmd(3'd2, 10'd10, "t2c");
        check("t2_count", q_count, 3);
        flag_b = 1'b1;
        repeat (5) begin
            if (InputLock) flag_b = 1'b0;
            @(negedge clk);
        end
        check("t2_blocked_by_busy", flag_b, 1);
        Busy = 1'b0;
        wait_lock(3'd2, 10'd7, "t2a", lat);
        motion(5, "t2a");
        wait_lock(3'd2, 10'd5, "t2b", lat);
        motion(5, "t2b");
        wait_lock(3'd2, 10'd10, "t2c", lat);
        motion(3, "t2c");
        wait_idle("t2");

        // Second command arrives during motion of the first.
        push_cmd(3'd0, 10'd10, "t3a");
        wait_lock(3'd0, 10'd10, "t3a", lat);
        Busy = 1'b1;
        repeat (3) @(negedge clk);
        push_cmd(3'd0, 10'd5, "t3b");
        flag_b = 1'b1;
        repeat (15) begin
            if (InputLock) flag_b = 1'b0;
            @(negedge clk);
        end
        check("t3_no_lock_while_busy", flag_b, 1);
        Busy = 1'b0;
        wait_lock(3'd0, 10'd5, "t3b", lat);
        check("t3_rise_after_busy_fall", lat, 4);
        expect_timeout("t3b");

        // Unhomed motor dropped, the following entry still served.
        InitFlag = 6'b111011;
        push_cmd(3'd2, 10'd4, "t4a");
        push_cmd(3'd1, 10'd6, "t4b");
        wait_drop(3'd2, "t4a", lat);
        wait_lock(3'd1, 10'd6, "t4b", lat);
        expect_timeout("t4b");

        // Fill to DEPTH; the ninth waits for a pop.
        InitFlag = 6'h3F;
        Busy = 1'b1;
        for (int i = 0; i < 8; i++) push_cmd(3'(i % 6), 10'(i * 37), $sformatf("t5_%0d", i));
        check("t5_full_count", q_count, 8);
        check("t5_full_ready", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_motor = 3'd2; cmd_value = 10'd296;
        flag_b = 1'b1;
        repeat (5) begin
            if (cmd_ready || q_count != 4'd8) flag_b = 1'b0;
            @(negedge clk);
        end
        check("t5_ninth_blocked", flag_b, 1);
        Busy = 1'b0;
        flag_b = 1'b0;
        for (int w = 0; w < 10 && !flag_b; w++) begin
            if (cmd_ready) flag_b = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("t5_ninth_accepted", flag_b, 1);
        for (int i = 0; i < 9; i++) begin
            wait_lock(3'(i % 6), 10'(i * 37), $sformatf("t5_%0d", i), lat);
            motion(1, "t5");
        end
        wait_idle("t5");

        // Reset in the middle of a lock pulse discards everything.
        push_cmd(3'd1, 10'd3, "t6a");
        push_cmd(3'd2, 10'd2, "t6b");
        push_cmd(3'd3, 10'd3, "t6c");
        lat = 0;
        while (!InputLock && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check("t6_lock_before_rst", InputLock, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_lock", InputLock, 0);
        check("t6_rst_count", q_count, 0);
        check("t6_rst_ready", cmd_ready, 0);
        rst = 1'b0;
        Busy = 1'b1;
        @(negedge clk);
        check("t6_not_idle_busy", idle, 0);
        Busy = 1'b0;
        @(negedge clk);
        check("t6_idle", idle, 1);
        flag_b = 1'b1;
        repeat (8) begin
            if (InputLock) flag_b = 1'b0;
            @(negedge clk);
        end
        check("t6_discarded", flag_b, 1);
        push_cmd(3'd1, 10'd3, "t6d");
        wait_lock(3'd1, 10'd3, "t6d", lat);
        expect_timeout("t6d");

        run_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Random traffic against a transaction-level scoreboard: the queue of
    // accepted commands must come out in order, each one either issued as a
    // 4-cycle lock pulse (valid, homed motor) or dropped, and only popped
    // while Busy was low.
    task automatic run_random();
        cmd_t exp_q[$];
        cmd_t e;
        bit   took = 1'b0, lock_prev = 1'b0, stable = 1'b1, draining = 1'b0;
        logic [2:0] bhist = '0;
        logic [2:0] lk_m = '0;
        logic [9:0] lk_v = '0;
        int   lock_len = 0, plan_delay = -1, plan_len = 0, busy_left = 0;
        int   cyc = 0, issued = 0, dropped = 0;
        InitFlag = 6'($urandom_range(0, 63));
        for (cyc = 0; cyc < 9000; cyc++) begin
            @(negedge clk);
            bhist = {bhist[1:0], Busy};
            if (InputLock && !lock_prev) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_lock", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_issue_allowed", 1, model_ok(e.m));
                    check("rnd_motor", Motor, e.m);
                    check("rnd_value", Value, e.v);
                    check("rnd_busy_at_pop", bhist[2], 0);
                    issued++;
                    $display("rnd issue motor=%0d value=%0d", Motor, Value);
                end
                lock_len = 1; lk_m = Motor; lk_v = Value; stable = 1'b1;
            end else if (InputLock) begin
                lock_len++;
                if (Motor !== lk_m || Value !== lk_v) stable = 1'b0;
            end
            if (!InputLock && lock_prev) begin
                check("rnd_lock_len", lock_len, 4);
                check("rnd_lock_held", stable, 1);
                if ($urandom_range(0, 3) != 0) begin
                    plan_delay = $urandom_range(0, 20);
                    plan_len   = $urandom_range(1, 12);
                end
            end
            if (err_drop) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_drop", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_drop_allowed", 0, model_ok(e.m));
                    check("rnd_drop_motor", Motor, e.m);
                    check("rnd_busy_at_drop_pop", bhist[0], 0);
                    dropped++;
                    $display("rnd drop motor=%0d", Motor);
                end
            end
            check("rnd_ready_vs_count", cmd_ready, (q_count != 4'd8));
            lock_prev = InputLock;

            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) Busy = 1'b0;
            end else if (plan_delay == 0) begin
                Busy = 1'b1;
                busy_left = plan_len;
                plan_delay = -1;
            end else if (plan_delay > 0) begin
                plan_delay--;
            end else if (!InputLock && $urandom_range(0, 99) == 0) begin
                plan_delay = 0;
                plan_len = $urandom_range(1, 8);
            end

            if (cyc >= 3000) draining = 1'b1;
            if (!cmd_valid || took) begin
                cmd_valid = !draining && ($urandom_range(0, 3) == 0);
                cmd_motor = 3'($urandom_range(0, 7));
                cmd_value = 10'($urandom);
            end
            took = cmd_valid && cmd_ready;
            if (took) exp_q.push_back({cmd_motor, cmd_value});
            if (draining && !cmd_valid && exp_q.size() == 0 && idle) break;
        end
        Busy = 1'b0;
        cmd_valid = 1'b0;
        check("rnd_drained", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        check("rnd_final_count", q_count, 0);
        check("rnd_final_idle", idle, 1);
        $display("rnd done cycles=%0d issued=%0d dropped=%0d", cyc, issued, dropped);
    endtask

endmodule
